banked_data_memory: RTL and testbench

- Parametrised byte-lane data memory for the CPU load/store path, built from NUM_LANES independent lane RAMs.
- Replaces externally driven per-lane chip selects. The block takes a byte address plus an access size and generates lane enables, write-data steering, and read-data alignment with sign/zero extension internally.
- Each request produces exactly one registered response, using a valid/ready handshake on both the request and response sides.
- Misaligned accesses are flagged and never modify memory.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/banked_data_memory_if.sv | 29 ++
 rtl/lane_ram.sv | 30 +++
 rtl/banked_data_memory.sv | 97 +++++++++
 tb/tb_banked_data_memory.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the banked data memory.
// Latency: none (pure types and functions).
// Backpressure: not applicable.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Encoding 3 is reserved; requests carrying it are rejected as errors.
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // Attributes of the in-flight response, captured when a request fires.
  typedef struct packed {
    logic       write;
    logic       err;
    logic       uns;
    logic [7:0] nbytes;
  } resp_ctl_t;

  function automatic int size_bytes(input mem_size_e size, input int num_lanes);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return num_lanes;
      default: return 1;
    endcase
  endfunction

  // Contiguous run of nbytes ones starting at lane 'offset'; callers truncate
  // to their lane count.
  function automatic logic [31:0] lane_mask(input int offset, input int nbytes);
    return ((32'd1 << nbytes) - 32'd1) << offset;
  endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// Request/response bundle between a load/store unit and the data memory.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the request and the response side.
interface banked_data_memory_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lane_ram.sv
// Single byte-lane RAM with synchronous, registered read port.
// Latency: 1 cycle from enable to rd; a write also returns the new data (write-first).
// Backpressure: none; rd holds its value while en is low.
module lane_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wd,
  output logic [WIDTH-1:0]         rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; rd only changes when the lane is enabled.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wd;
        rd        <= wd;
      end else begin
        rd <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/banked_data_memory.sv
// Byte-lane data memory: lane enables, store steering, load alignment and extension.
// Latency: response valid exactly 1 cycle after a request fires; 1 request/cycle.
// Backpressure: single response slot; req_ready drops while a response is stalled.
module banked_data_memory
  import mem_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input logic                  clk,
  input logic                  rst,
  banked_data_memory_if.slave  bus
);

  localparam int OFF_W      = $clog2(NUM_LANES);
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int DATA_WIDTH = NUM_LANES * LANE_WIDTH;
  localparam int ADDR_WIDTH = IDX_W + OFF_W;

  logic                  fire;
  logic [OFF_W-1:0]      req_off;
  logic [IDX_W-1:0]      req_idx;
  int                    req_bytes;
  logic                  req_err;
  logic [NUM_LANES-1:0]  lane_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic                  sign_bit;
  logic                  resp_valid_q;
  resp_ctl_t             pend;
  logic [OFF_W-1:0]      pend_off;

  assign bus.req_ready = !rst && (!resp_valid_q || bus.resp_ready);
  assign fire          = bus.req_valid && bus.req_ready;

  // Decode the fired request into lane enables and lane-positioned store data.
  always_comb begin
    req_off   = bus.req_addr[OFF_W-1:0];
    req_idx   = bus.req_addr[ADDR_WIDTH-1:OFF_W];
    req_bytes = (bus.req_size == SZ_ILLEGAL) ? 1
              : size_bytes(mem_size_e'(bus.req_size), NUM_LANES);
    req_err   = (bus.req_size == SZ_ILLEGAL) || ((int'(req_off) & (req_bytes - 1)) != 0);
    lane_en   = (fire && !req_err) ? NUM_LANES'(lane_mask(int'(req_off), req_bytes)) : '0;
    wdata_sh  = bus.req_wdata << (int'(req_off) * LANE_WIDTH);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_ram #(.WIDTH(LANE_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .en   (lane_en[i]),
      .we   (bus.req_write),
      .addr (req_idx),
      .wd   (wdata_sh[i*LANE_WIDTH +: LANE_WIDTH]),
      .rd   (rd_word[i*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // Single response slot: capture on fire, release when the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      pend         <= '0;
      pend_off     <= '0;
    end else if (fire) begin
      resp_valid_q <= 1'b1;
      pend.write   <= bus.req_write;
      pend.err     <= req_err;
      pend.uns     <= bus.req_unsigned;
      pend.nbytes  <= 8'(req_bytes);
      pend_off     <= req_off;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Align the registered lane data to bit 0 and extend past the access width.
  always_comb begin
    rd_shift = rd_word >> (int'(pend_off) * LANE_WIDTH);
    sign_bit = rd_shift[int'(pend.nbytes) * LANE_WIDTH - 1] && !pend.uns;
    rd_ext   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i < int'(pend.nbytes)) begin
        rd_ext[i*LANE_WIDTH +: LANE_WIDTH] = rd_shift[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        rd_ext[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{sign_bit}};
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_valid_q && pend.err;
  assign bus.resp_rdata = (resp_valid_q && !pend.write && !pend.err) ? rd_ext : '0;

endmodule

// File: tb/tb_banked_data_memory.sv
module tb_banked_data_memory;

  logic clk;
  logic rst;

  banked_data_memory_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

  banked_data_memory #(.NUM_LANES(4), .LANE_WIDTH(8), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mm [128];
  exp_t        q [$];
  logic        rst_q = 1'b0;
  logic [31:0] exp3 [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte-addressed reference memory; returns the response a request must produce.
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [6:0] a, input logic [31:0] wd);
    exp_t        r;
    int          n;
    logic [31:0] v;
    r.d = 32'h0;
    r.e = 1'b0;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (int'(a) % n) != 0) begin
      r.e = 1'b1;
      return r;
    end
    if (w) begin
      for (int b = 0; b < n; b++) mm[int'(a) + b] = wd[8*b +: 8];
      return r;
    end
    v = 32'h0;
    for (int b = 0; b < n; b++) v = v | (32'(mm[int'(a) + b]) << (8 * b));
    if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    r.d = v;
    return r;
  endfunction

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready_during_rst", bus.req_ready, 0);
      q.delete();
    end else begin
      if (rst_q) begin
        chk("post_rst_valid", bus.resp_valid, 0);
        chk("post_rst_rdata", bus.resp_rdata, 0);
        chk("post_rst_error", bus.resp_error, 0);
      end
      chk("req_ready_rule", bus.req_ready, 32'(!bus.resp_valid || bus.resp_ready));
      chk("resp_valid_vs_model", bus.resp_valid, 32'(q.size() != 0));
      if (bus.resp_valid && q.size() != 0) begin
        chk("model_rdata", bus.resp_rdata, q[0].d);
        chk("model_error", bus.resp_error, 32'(q[0].e));
        if (bus.resp_ready) void'(q.pop_front());
      end
      if (bus.req_valid && bus.req_ready)
        q.push_back(model(bus.req_write, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata));
    end
    rst_q = rst;
  end

  // Present one request and hold it until it fires; returns just after the firing edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [6:0] a, input logic [31:0] wd);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string nm, input logic [31:0] d, input logic e);
    @(negedge clk);
    chk({nm, "_valid"}, bus.resp_valid, 1);
    chk({nm, "_rdata"}, bus.resp_rdata, d);
    chk({nm, "_error"}, bus.resp_error, 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Known contents everywhere: word i = 0xA50000ii.
    for (int i = 0; i < 32; i++) send(1, 2'd2, 0, 7'(i * 4), 32'hA500_0000 | 32'(i));

    send(1, 2'd2, 0, 7'h04, 32'hDEADBEEF);
    send(0, 2'd2, 0, 7'h04, 0);  expect_resp("word_load_04", 32'hDEADBEEF, 0);
    send(1, 2'd0, 0, 7'h05, 32'h0000_0080);
    send(0, 2'd0, 0, 7'h05, 0);  expect_resp("sbyte_load_05", 32'hFFFFFF80, 0);
    send(0, 2'd0, 1, 7'h05, 0);  expect_resp("ubyte_load_05", 32'h00000080, 0);
    send(0, 2'd2, 0, 7'h04, 0);  expect_resp("word_after_byte", 32'hDEAD80EF, 0);
    send(1, 2'd1, 0, 7'h06, 32'h0000_1234);
    send(0, 2'd1, 0, 7'h06, 0);  expect_resp("shalf_load_06", 32'h00001234, 0);
    send(0, 2'd1, 0, 7'h05, 0);  expect_resp("misaligned_half_load", 32'h0, 1);
    send(1, 2'd1, 0, 7'h05, 32'h0000_FFFF); expect_resp("misaligned_half_store", 32'h0, 1);
    send(0, 2'd2, 0, 7'h04, 0);  expect_resp("word_unchanged_04", 32'h123480EF, 0);
    send(0, 2'd3, 0, 7'h00, 0);  expect_resp("illegal_size_load", 32'h0, 1);
    send(1, 2'd3, 0, 7'h00, 32'hFFFFFFFF); expect_resp("illegal_size_store", 32'h0, 1);
    send(0, 2'd2, 0, 7'h00, 0);  expect_resp("word_unchanged_00", 32'hA5000000, 0);

    // Back-to-back word loads with the consumer always ready.
    exp3[0] = 32'hA5000000;
    exp3[1] = 32'h123480EF;
    exp3[2] = 32'hA5000002;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'd2;
      bus.req_addr  = 7'(k * 4);
      @(negedge clk);
      chk("b2b_req_ready", bus.req_ready, 1);
      if (k > 0) begin
        chk("b2b_valid", bus.resp_valid, 1);
        chk("b2b_rdata", bus.resp_rdata, exp3[k-1]);
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_last", bus.resp_valid, 1);
    chk("b2b_rdata_last", bus.resp_rdata, exp3[2]);
    @(posedge clk);
    #1;

    // Same loads with the consumer stalled for 3 cycles.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 7'h00;
    @(negedge clk);
    chk("stall_first_ready", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_addr = 7'h04;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_valid", bus.resp_valid, 1);
      chk("stall_rdata", bus.resp_rdata, 32'hA5000000);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", bus.req_ready, 1);
    chk("stall_release_rdata", bus.resp_rdata, 32'hA5000000);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("stall_second_valid", bus.resp_valid, 1);
    chk("stall_second_rdata", bus.resp_rdata, 32'h123480EF);
    @(posedge clk);
    #1;

    // Reset while a response is pending, with a store presented during reset.
    bus.resp_ready = 1'b0;
    send(0, 2'd2, 0, 7'h00, 0);
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 7'h00;
    bus.req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_pending_valid", bus.resp_valid, 1);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("rst_dropped_valid", bus.resp_valid, 0);
    @(posedge clk);
    #1;
    send(0, 2'd2, 0, 7'h00, 0);  expect_resp("rst_store_ignored", 32'hA5000000, 0);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 299) == 0);
      bus.req_valid    = ($urandom_range(0, 3) != 0);
      bus.req_write    = 1'($urandom_range(0, 1));
      bus.req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.req_unsigned = 1'($urandom_range(0, 1));
      bus.req_addr     = 7'($urandom_range(0, 127));
      bus.req_wdata    = $urandom;
      bus.resp_ready   = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained_valid", bus.resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
